// File: rtl/mem_loader.sv
// Stream-driven boot loader: fills NUM_CH memories from a valid/ready word stream, holds the core
// in reset until RUN. Optional payload checksum stage when LOADER_CHECKSUM_EN is defined.
module mem_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_CH     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]     wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  proc_rst,
    output logic                  loading,
    output logic                  error
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CMD_LOAD = 4'h1;
    localparam logic [3:0]  CMD_RUN  = 4'h2;
    localparam logic [3:0]  CMD_HALT = 4'h3;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StLoad, StChk, StRun, StErr} state_t;
    logic [DATA_WIDTH-1:0] sum_q;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StRun, StErr} state_t;
`endif

    state_t              state_q;
    logic [3:0]          ch_q;
    logic [ADDR_WIDTH:0] addr_q;
    logic [ADDR_WIDTH:0] cnt_q;

    logic [3:0]          hdr_cmd;
    logic [3:0]          hdr_ch;
    logic [23:0]         hdr_cnt;
    logic                accept;
    logic                hdr_bad;
    logic [ADDR_WIDTH:0] addr_nxt;
    logic [NUM_CH-1:0]   ch_onehot;

    assign hdr_cmd   = in_data[31:28];
    assign hdr_ch    = in_data[27:24];
    assign hdr_cnt   = in_data[23:0];
    assign accept    = in_valid & in_ready;
    assign hdr_bad   = (32'(hdr_ch) >= NUM_CH) || (32'(hdr_cnt) > DEPTH);
    // One extra counter bit lets cnt == DEPTH finish without wrapping to 0.
    assign addr_nxt  = addr_q + (ADDR_WIDTH + 1)'(1);
    assign ch_onehot = NUM_CH'(1) << ch_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            wr_en    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            proc_rst <= 1'b1;
            loading  <= 1'b0;
            error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            in_ready <= (state_q != StErr);
            wr_en    <= '0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (hdr_cmd)
                            CMD_LOAD: begin
                                if (hdr_bad) begin
                                    state_q  <= StErr;
                                    error    <= 1'b1;
                                    in_ready <= 1'b0;
                                end else if (hdr_cnt != '0) begin
                                    state_q <= StLoad;
                                    ch_q    <= hdr_ch;
                                    cnt_q   <= hdr_cnt[ADDR_WIDTH:0];
                                    addr_q  <= '0;
                                    loading <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                                    sum_q   <= '0;
`endif
                                end
                            end
                            CMD_RUN: begin
                                state_q  <= StRun;
                                proc_rst <= 1'b0;
                            end
                            CMD_HALT: state_q <= StIdle;
                            default: begin
                                state_q  <= StErr;
                                error    <= 1'b1;
                                in_ready <= 1'b0;
                            end
                        endcase
                    end
                end
                StLoad: begin
                    if (accept) begin
                        wr_en   <= ch_onehot;
                        wr_addr <= addr_q[ADDR_WIDTH-1:0];
                        wr_data <= in_data;
                        addr_q  <= addr_nxt;
`ifdef LOADER_CHECKSUM_EN
                        sum_q   <= sum_q + in_data;
                        if (addr_nxt == cnt_q) begin
                            state_q <= StChk;
                        end
`else
                        if (addr_nxt == cnt_q) begin
                            state_q <= StIdle;
                            loading <= 1'b0;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StChk: begin
                    if (accept) begin
                        loading <= 1'b0;
                        if (in_data == sum_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q  <= StErr;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
`endif
                StRun: begin
                    if (accept && hdr_cmd == CMD_HALT) begin
                        state_q  <= StIdle;
                        proc_rst <= 1'b1;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized scoreboard bench for mem_loader: expected writes are queued by stimulus tasks and
// popped by an independent write monitor.
module tb_mem_loader;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [2:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        proc_rst;
    logic        loading;
    logic        error;

    mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_CH(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .proc_rst(proc_rst),
        .loading(loading), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst && wr_en != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wr_en), 32'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_en", 32'(wr_en), 32'(1) << e.ch);
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    function automatic logic [31:0] mk_hdr(logic [3:0] cmd, logic [3:0] ch, logic [23:0] cnt);
        return {cmd, ch, cnt};
    endfunction

    // Present one word for exactly one cycle, optionally preceded by idle bubbles.
    task automatic put(input logic [31:0] w, input bit bubble, input bit exp_acc);
        logic acc;
        if (bubble) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = $urandom;
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        acc      = in_ready;
        @(posedge clk);
        check("accept", 32'(acc), 32'(exp_acc));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_proc_rst", 32'(proc_rst), 32'h1);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        check("post_rst_loading", 32'(loading), 32'h0);
    endtask

    // Whole LOAD transaction: header, cnt payload words, then the checksum word if enabled.
    task automatic do_load(input int ch, input int cnt, input bit bubble);
        logic [31:0] d;
        logic [31:0] sum;
        sum = '0;
        put(mk_hdr(4'h1, 4'(ch), 24'(cnt)), bubble, 1'b1);
        for (int i = 0; i < cnt; i++) begin
            d = $urandom;
            exp_q.push_back('{ch: ch, addr: i, data: d});
            sum = sum + d;
            put(d, bubble, 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        put(sum, bubble, 1'b1);
`endif
    endtask

    task automatic do_run(input int junk, input bit bubble);
        logic [31:0] w;
        put(32'h2000_0000, bubble, 1'b1);
        idle();
        check("run_proc_rst", 32'(proc_rst), 32'h0);
        for (int i = 0; i < junk; i++) begin
            w = $urandom;
            if (w[31:28] == 4'h3) w[31:28] = 4'h1;
            put(w, bubble, 1'b1);
        end
        idle();
        check("run_hold_proc_rst", 32'(proc_rst), 32'h0);
        put(32'h3000_0000, bubble, 1'b1);
        idle();
        check("halt_proc_rst", 32'(proc_rst), 32'h1);
    endtask

    task automatic expect_err(input logic [31:0] hdr, input string name);
        put(hdr, 1'b0, 1'b1);
        idle();
        check({name, "_error"}, 32'(error), 32'h1);
        check({name, "_in_ready"}, 32'(in_ready), 32'h0);
        put(mk_hdr(4'h1, 4'h0, 24'd1), 1'b0, 1'b0);
        put(32'h2000_0000, 1'b0, 1'b0);
        repeat (4) idle();
        check({name, "_sticky"}, 32'(error), 32'h1);
        check({name, "_proc_rst"}, 32'(proc_rst), 32'h1);
        do_reset();
        check({name, "_cleared"}, 32'(error), 32'h0);
    endtask

    initial begin
        do_reset();

        // Back-to-back LOAD ch0 of four words.
        put(32'h1000_0004, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{ch: 0, addr: i, data: 32'((i + 1) * 32'h11)});
            put(32'((i + 1) * 32'h11), 1'b0, 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        put(32'h0000_00AA, 1'b0, 1'b1);
`endif
        idle();
        idle();
        check("t2_loading", 32'(loading), 32'h0);
        check("t2_drained", 32'(exp_q.size()), 32'h0);

        // LOAD ch1 cnt2 with in_valid toggling; loading must be up mid-transfer.
        put(32'h1100_0002, 1'b0, 1'b1);
        idle();
        check("t3_loading", 32'(loading), 32'h1);
        exp_q.push_back('{ch: 1, addr: 0, data: 32'hCAFE_0001});
        put(32'hCAFE_0001, 1'b0, 1'b1);
        idle();
        exp_q.push_back('{ch: 1, addr: 1, data: 32'hCAFE_0002});
        put(32'hCAFE_0002, 1'b0, 1'b1);
        idle();
`ifdef LOADER_CHECKSUM_EN
        put(32'h95FC_0003, 1'b0, 1'b1);
        idle();
`endif
        check("t3_loading_done", 32'(loading), 32'h0);

        // RUN, a LOAD-looking word that must be dropped, then HALT.
        do_run(1, 1'b0);
        do_run(3, 1'b1);

        // cnt == 0 is a no-op, HALT in IDLE is a no-op.
        put(32'h1200_0000, 1'b0, 1'b1);
        put(32'h3000_0000, 1'b0, 1'b1);
        idle();
        check("cnt0_loading", 32'(loading), 32'h0);
        check("cnt0_error", 32'(error), 32'h0);

        // Full-depth load must cover every address with no wrap.
        do_load(2, DEPTH, 1'b0);
        idle();
        check("depth_error", 32'(error), 32'h0);
        check("depth_loading", 32'(loading), 32'h0);

        // Reset mid-LOAD abandons the transfer; a fresh LOAD restarts at address 0.
        put(32'h1200_0004, 1'b0, 1'b1);
        exp_q.push_back('{ch: 2, addr: 0, data: 32'h0000_BEEF});
        put(32'h0000_BEEF, 1'b0, 1'b1);
        exp_q.push_back('{ch: 2, addr: 1, data: 32'h0000_F00D});
        put(32'h0000_F00D, 1'b0, 1'b1);
        do_reset();
        do_load(2, 3, 1'b0);
        idle();

        // Randomized mix of legal traffic.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                do_load($urandom_range(0, 2), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
            end else if (r <= 6) begin
                do_run($urandom_range(0, 4), 1'($urandom_range(0, 1)));
            end else if (r == 7) begin
                put(32'h3000_0000, 1'b1, 1'b1);
            end else begin
                put(mk_hdr(4'h1, 4'($urandom_range(0, 2)), 24'd0), 1'b1, 1'b1);
            end
            idle();
            check("rand_loading", 32'(loading), 32'h0);
            check("rand_error", 32'(error), 32'h0);
            check("rand_proc_rst", 32'(proc_rst), 32'h1);
        end

`ifdef LOADER_CHECKSUM_EN
        put(32'h1000_0002, 1'b0, 1'b1);
        exp_q.push_back('{ch: 0, addr: 0, data: 32'd5});
        put(32'd5, 1'b0, 1'b1);
        exp_q.push_back('{ch: 0, addr: 1, data: 32'd7});
        put(32'd7, 1'b0, 1'b1);
        idle();
        check("chk_loading", 32'(loading), 32'h1);
        put(32'd12, 1'b0, 1'b1);
        idle();
        check("chk_ok_error", 32'(error), 32'h0);
        check("chk_ok_loading", 32'(loading), 32'h0);
        put(32'h1000_0002, 1'b0, 1'b1);
        exp_q.push_back('{ch: 0, addr: 0, data: 32'd5});
        put(32'd5, 1'b0, 1'b1);
        exp_q.push_back('{ch: 0, addr: 1, data: 32'd7});
        put(32'd7, 1'b0, 1'b1);
        put(32'd13, 1'b0, 1'b1);
        idle();
        check("chk_bad_error", 32'(error), 32'h1);
        check("chk_bad_in_ready", 32'(in_ready), 32'h0);
        do_reset();
`endif

        // Illegal headers: bad channel, oversize count, unknown command.
        expect_err(32'h1300_0001, "bad_ch");
        expect_err(mk_hdr(4'h1, 4'h0, 24'(DEPTH + 1)), "bad_cnt");
        expect_err(32'h5000_0000, "bad_cmd");
        expect_err(32'h0000_0000, "zero_cmd");

        repeat (3) idle();
        check("final_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
